// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: write-back control bits, default widths, MEM/WB payload.
package mips_pkg;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;
  localparam int unsigned WB_W_DEF   = 2;
  localparam int unsigned CNT_W_DEF  = 16;

  // MEM/WB payload at default widths; the field order matches the flat packing in mem_wb_pipe
  typedef struct packed {
    logic [DATA_W_DEF-1:0] readData;
    logic [DATA_W_DEF-1:0] aluResult;
    logic [REG_W_DEF-1:0]  muxInst;
    logic [WB_W_DEF-1:0]   WB;
  } mem_wb_t;

  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-slot valid/ready buffer: a main slot that drives the outputs and a skid slot.
// in_ready comes straight from a flop, so out_ready never reaches it combinationally.
module pipe_skid_buf #(
  parameter int unsigned PAY_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAY_W-1:0] in_pay,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PAY_W-1:0] out_pay
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             accept;
  logic             pop;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_pay   = main_q;
  assign accept    = in_valid & ~skid_valid_q;
  assign pop       = main_valid_q & out_ready;

  // Slot steering: flush kills both slots, otherwise keep strict FIFO order
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || (pop && !skid_valid_q)) begin
      main_valid_d = accept;
      if (accept) main_d = in_pay;
    end else if (pop) begin
      // skid is full here, so in_ready was low and nothing was accepted
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_d       = in_pay;
      skid_valid_d = 1'b1;
    end
  end

  // Slot registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: skid-buffered handshake, register-file write enable,
// write-back forwarding tap and a saturating stall counter.
module mem_wb_pipe
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF,
  parameter int unsigned WB_W   = WB_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] readData,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [REG_W-1:0]  muxInst,
  input  logic [WB_W-1:0]   WB,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] readDataOut,
  output logic [DATA_W-1:0] aluResultOut,
  output logic [REG_W-1:0]  muxInstOut,
  output logic [WB_W-1:0]   WBOut,
  output logic              rf_we,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PAY_W = 2 * DATA_W + REG_W + WB_W;

  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign pay_in = {readData, aluResult, muxInst, WB};

  pipe_skid_buf #(
    .PAY_W(PAY_W)
  ) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pay    (pay_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pay   (pay_out)
  );

  assign {readDataOut, aluResultOut, muxInstOut, WBOut} = pay_out;

  // Register-file write and forwarding tap; writes to x0 are suppressed
  assign rf_we     = out_valid & WBOut[WB_REGWRITE] & (muxInstOut != '0);
  assign fwd_valid = rf_we;
  assign fwd_reg   = muxInstOut;
  assign fwd_data  = WBOut[WB_MEMTOREG] ? readDataOut : aluResultOut;

  // Saturating count of cycles where the head is held by the consumer
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register; flush deliberately leaves it alone
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed testbench for mem_wb_pipe; inputs change 1 time unit after the
// rising edge and outputs are checked at that same point.
module tb_mem_wb_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] readData;
  logic [31:0] aluResult;
  logic [4:0]  muxInst;
  logic [1:0]  WB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] readDataOut;
  logic [31:0] aluResultOut;
  logic [4:0]  muxInstOut;
  logic [1:0]  WBOut;
  logic        rf_we;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_pipe dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .readData     (readData),
    .aluResult    (aluResult),
    .muxInst      (muxInst),
    .WB           (WB),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .readDataOut  (readDataOut),
    .aluResultOut (aluResultOut),
    .muxInstOut   (muxInstOut),
    .WBOut        (WBOut),
    .rf_we        (rf_we),
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_data     (fwd_data),
    .stall_cnt    (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] rg, input logic [1:0] wb);
    in_valid  = v;
    readData  = rd;
    aluResult = alu;
    muxInst   = rg;
    WB        = wb;
  endtask

  initial begin
    // Reset with junk on the inputs
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31, 2'b11);
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_readDataOut", 64'(readDataOut), 64'd0);
    check("rst_aluResultOut", 64'(aluResultOut), 64'd0);
    check("rst_muxInstOut", 64'(muxInstOut), 64'd0);
    check("rst_WBOut", 64'(WBOut), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    reset_n = 1'b1;
    step();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Streaming: 8 back-to-back entries, each visible one cycle after acceptance
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hA000 + 32'(i), 32'h100 + 32'(i), 5'(i + 1), 2'b10);
      step();
      check("str_out_valid", 64'(out_valid), 64'd1);
      check("str_alu", 64'(aluResultOut), 64'h100 + 64'(i));
      check("str_reg", 64'(muxInstOut), 64'(i + 1));
      check("str_fwd_data", 64'(fwd_data), 64'h100 + 64'(i));
      check("str_rf_we", 64'(rf_we), 64'd1);
      check("str_in_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    step();
    check("str_drained", 64'(out_valid), 64'd0);
    check("str_stall_cnt", 64'(stall_cnt), 64'd0);

    // Backpressure: consumer stalled while three entries are offered
    out_ready = 1'b0;
    drive(1'b1, 32'd0, 32'h200, 5'd1, 2'b10);
    step();
    check("bp_e0_valid", 64'(out_valid), 64'd1);
    check("bp_e0_in_ready", 64'(in_ready), 64'd1);
    check("bp_e0_head", 64'(aluResultOut), 64'h200);
    drive(1'b1, 32'd0, 32'h201, 5'd2, 2'b10);
    step();
    check("bp_skid_in_ready", 64'(in_ready), 64'd0);
    check("bp_skid_head", 64'(aluResultOut), 64'h200);
    check("bp_stall1", 64'(stall_cnt), 64'd1);
    drive(1'b1, 32'd0, 32'h202, 5'd3, 2'b10);
    step();
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_stall2", 64'(stall_cnt), 64'd2);
    step();
    check("bp_stall3", 64'(stall_cnt), 64'd3);
    check("bp_head_hold", 64'(aluResultOut), 64'h200);
    out_ready = 1'b1;
    step();
    check("bp_deliver1", 64'(aluResultOut), 64'h201);
    check("bp_reopen", 64'(in_ready), 64'd1);
    step();
    check("bp_deliver2", 64'(aluResultOut), 64'h202);
    check("bp_deliver2_reg", 64'(muxInstOut), 64'd3);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_stall_hold", 64'(stall_cnt), 64'd3);

    // Forward select and x0 guard
    drive(1'b1, 32'hDEAD_BEEF, 32'h4, 5'd7, 2'b11);
    step();
    check("fwd_data_mem", 64'(fwd_data), 64'hDEAD_BEEF);
    check("fwd_valid", 64'(fwd_valid), 64'd1);
    check("fwd_reg", 64'(fwd_reg), 64'd7);
    drive(1'b1, 32'hDEAD_BEEF, 32'h4, 5'd0, 2'b11);
    step();
    check("x0_rf_we", 64'(rf_we), 64'd0);
    check("x0_fwd_valid", 64'(fwd_valid), 64'd0);
    check("x0_fwd_data", 64'(fwd_data), 64'hDEAD_BEEF);
    drive(1'b1, 32'hDEAD_BEEF, 32'h4, 5'd3, 2'b01);
    step();
    check("nowrite_rf_we", 64'(rf_we), 64'd0);
    drive(1'b1, 32'hDEAD_BEEF, 32'h4, 5'd3, 2'b10);
    step();
    check("fwd_data_alu", 64'(fwd_data), 64'h4);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    step();

    // Flush with both slots full and a new entry offered
    out_ready = 1'b0;
    drive(1'b1, 32'd0, 32'h300, 5'd4, 2'b10);
    step();
    drive(1'b1, 32'd0, 32'h301, 5'd5, 2'b10);
    step();
    check("fl_full", 64'(in_ready), 64'd0);
    check("fl_stall_pre", 64'(stall_cnt), 64'd4);
    drive(1'b1, 32'd0, 32'h302, 5'd6, 2'b10);
    flush = 1'b1;
    step();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_rf_we", 64'(rf_we), 64'd0);
    check("fl_stall_kept", 64'(stall_cnt), 64'd5);
    check("fl_data_kept", 64'(aluResultOut), 64'h300);
    // Entry accepted during a flush into an empty stage is dropped
    out_ready = 1'b1;
    drive(1'b1, 32'd0, 32'h3FF, 5'd6, 2'b10);
    step();
    check("fl_accept_dropped", 64'(out_valid), 64'd0);
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    step();
    check("fl_no_ghost", 64'(out_valid), 64'd0);

    // Asynchronous reset with both slots full
    out_ready = 1'b0;
    drive(1'b1, 32'd0, 32'h400, 5'd8, 2'b10);
    step();
    drive(1'b1, 32'd0, 32'h401, 5'd9, 2'b10);
    step();
    check("ar_full", 64'(in_ready), 64'd0);
    check("ar_stall_pre", 64'(stall_cnt), 64'd6);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    check("ar_stall_clr", 64'(stall_cnt), 64'd0);
    check("ar_data_clr", 64'(aluResultOut), 64'd0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'd0, 32'h500, 5'd9, 2'b10);
    step();
    check("ar_restart_valid", 64'(out_valid), 64'd1);
    check("ar_restart_alu", 64'(aluResultOut), 64'h500);
    check("ar_restart_rf_we", 64'(rf_we), 64'd1);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    step();
    check("ar_restart_drain", 64'(out_valid), 64'd0);
    check("ar_restart_stall", 64'(stall_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
